// File: rtl/ram_copy_pkg.sv
// Shared widths and FSM state encoding for the RAM512 block copier.
package ram_copy_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ram512_block_copier.sv
// Block copier for a 512-word RAM: moves len words from src to dst with memmove
// semantics, one RAM access per cycle (alternating READ / WRITE).
module ram512_block_copier #(
  parameter int ADDR_W = ram_copy_pkg::ADDR_W,
  parameter int DATA_W = ram_copy_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_dout
);

  import ram_copy_pkg::*;

  localparam logic [ADDR_W:0]   MAX_LEN  = ADDR_W'(1) << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  state_t state, state_next;

  logic [ADDR_W-1:0] src_cur, dst_cur;
  logic [ADDR_W:0]   remaining;
  logic [DATA_W-1:0] hold;
  logic              desc;

  logic [ADDR_W:0]   len_eff;
  logic [ADDR_W-1:0] len_m1;
  logic [ADDR_W-1:0] diff;
  logic              desc_start;

  // Descending order is needed whenever dst lands inside the source window
  // (measured circularly), otherwise a forward copy would clobber unread words.
  always_comb begin
    len_eff    = (len > MAX_LEN) ? MAX_LEN : len;
    len_m1     = len_eff[ADDR_W-1:0] - ADDR_ONE;
    diff       = dst - src;
    desc_start = (dst != src) && ({1'b0, diff} < len_eff);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (len_eff == '0) ? DONE : READ;
        end
      end
      READ:  state_next = WRITE;
      WRITE: state_next = (remaining == CNT_ONE) ? DONE : READ;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Cursors, word counter and the hold register that carries data from READ to WRITE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_cur   <= '0;
      dst_cur   <= '0;
      remaining <= '0;
      hold      <= '0;
      desc      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            desc      <= desc_start;
            remaining <= len_eff;
            src_cur   <= desc_start ? src + len_m1 : src;
            dst_cur   <= desc_start ? dst + len_m1 : dst;
          end
        end
        READ: begin
          hold <= mem_dout;
        end
        WRITE: begin
          remaining <= remaining - CNT_ONE;
          src_cur   <= desc ? src_cur - ADDR_ONE : src_cur + ADDR_ONE;
          dst_cur   <= desc ? dst_cur - ADDR_ONE : dst_cur + ADDR_ONE;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    mem_load = 1'b0;
    case (state)
      READ: begin
        busy     = 1'b1;
        mem_addr = src_cur;
      end
      WRITE: begin
        busy     = 1'b1;
        mem_addr = dst_cur;
        mem_din  = hold;
        mem_load = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ram512_block_copier.sv
// Self-checking bench: a behavioural RAM512 plus a memmove reference model built
// from a temporary buffer, compared against the copier after each transfer.
module tb_ram512_block_copier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [8:0]  src;
  logic [8:0]  dst;
  logic [9:0]  len;
  logic        busy;
  logic        done;
  logic [8:0]  mem_addr;
  logic [15:0] mem_din;
  logic        mem_load;
  logic [15:0] mem_dout;

  logic [15:0] ram [512];
  logic [15:0] exp_mem [512];

  logic        pre_we;
  logic [8:0]  pre_addr;
  logic [15:0] pre_data;

  int checks;
  int errors;
  int busy_cnt;
  int done_cnt;
  int done_cycle;
  int extra_busy;
  int stray_load;
  int load_cnt;
  int addr_trace[$];
  int load_trace[$];

  ram512_block_copier dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_load (mem_load),
    .mem_dout (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM512 model: combinational read, write on the rising edge; the preload port lets the bench seed contents.
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_load) ram[mem_addr] <= mem_din;
  end
  assign mem_dout = ram[mem_addr];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pokeWord(input int a, input int v);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = 9'(a);
    pre_data = 16'(v);
    exp_mem[a % 512] = 16'(v);
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Reference memmove: read the whole source window first, then write it out.
  task automatic modelCopy(input int s, input int d, input int l);
    logic [15:0] tmp[$];
    int n;
    n = (l > 512) ? 512 : l;
    for (int i = 0; i < n; i++) tmp.push_back(exp_mem[(s + i) % 512]);
    for (int i = 0; i < n; i++) exp_mem[(d + i) % 512] = tmp[i];
  endtask

  task automatic checkMemory(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 512; i++) if (ram[i] !== exp_mem[i]) bad++;
    checkOutput(tag, bad, 0);
  endtask

  task automatic applyStimulus(input int s, input int d, input int l, input int mid_start_at);
    int cycles;
    @(negedge clk);
    src   = 9'(s);
    dst   = 9'(d);
    len   = 10'(l);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cnt   = 0;
    done_cnt   = 0;
    done_cycle = -1;
    extra_busy = 0;
    stray_load = 0;
    load_cnt   = 0;
    cycles     = 0;
    addr_trace.delete();
    load_trace.delete();
    while (done_cnt == 0 && cycles < 1100) begin
      if (busy) begin
        busy_cnt++;
        addr_trace.push_back(int'(mem_addr));
        load_trace.push_back(int'(mem_load));
      end else if (mem_load) begin
        stray_load++;
      end
      if (mem_load) load_cnt++;
      if (done) begin
        done_cnt++;
        done_cycle = cycles;
      end
      if (cycles == mid_start_at) begin
        src   = 9'($urandom_range(511, 0));
        dst   = 9'($urandom_range(511, 0));
        len   = 10'd3;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      cycles++;
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done) done_cnt++;
      if (busy) extra_busy++;
      if (mem_load) stray_load++;
      @(negedge clk);
    end
  endtask

  task automatic checkTiming(input string tag, input int l);
    int n;
    int alt_bad;
    n = (l > 512) ? 512 : l;
    alt_bad = 0;
    foreach (load_trace[i]) if (load_trace[i] != (i % 2)) alt_bad++;
    checkOutput({tag, "_busy_cycles"}, busy_cnt, 2 * n);
    checkOutput({tag, "_done_cycle"}, done_cycle, 2 * n);
    checkOutput({tag, "_done_pulses"}, done_cnt, 1);
    checkOutput({tag, "_extra_busy"}, extra_busy, 0);
    checkOutput({tag, "_load_pattern"}, alt_bad, 0);
    checkOutput({tag, "_stray_load"}, stray_load, 0);
    checkOutput({tag, "_load_count"}, load_cnt, n);
  endtask

  initial begin
    int s, d, l, writes, cyc;
    int wrap_exp[6];
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    src      = '0;
    dst      = '0;
    len      = '0;
    pre_we   = 1'b0;
    pre_addr = '0;
    pre_data = '0;

    for (int i = 0; i < 512; i++) pokeWord(i, int'($urandom_range(65535, 0)));

    @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_load", mem_load, 0);
    checkOutput("reset_addr", mem_addr, 0);
    checkOutput("reset_din", mem_din, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) pokeWord(10 + i, i + 1);
    modelCopy(10, 100, 4);
    applyStimulus(10, 100, 4, 3);
    checkTiming("basic", 4);
    checkMemory("basic_mem");

    for (int i = 0; i < 5; i++) pokeWord(20 + i, 16'hA + i);
    modelCopy(20, 22, 5);
    applyStimulus(20, 22, 5, -1);
    checkTiming("fwd_overlap", 5);
    checkOutput("fwd_overlap_first_write", addr_trace[1], 26);
    checkMemory("fwd_overlap_mem");

    for (int i = 0; i < 5; i++) pokeWord(30 + i, 16'hA + i);
    modelCopy(30, 28, 5);
    applyStimulus(30, 28, 5, -1);
    checkTiming("bwd_overlap", 5);
    checkOutput("bwd_overlap_first_write", addr_trace[1], 28);
    checkMemory("bwd_overlap_mem");

    pokeWord(510, 7);
    pokeWord(511, 8);
    pokeWord(0, 9);
    modelCopy(510, 200, 3);
    applyStimulus(510, 200, 3, -1);
    checkTiming("wrap", 3);
    wrap_exp = '{510, 200, 511, 201, 0, 202};
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("wrap_addr%0d", i), (i < addr_trace.size()) ? addr_trace[i] : -1, wrap_exp[i]);
    end
    checkMemory("wrap_mem");

    applyStimulus(40, 60, 0, -1);
    checkTiming("len0", 0);
    checkMemory("len0_mem");

    modelCopy(5, 5, 700);
    applyStimulus(5, 5, 700, -1);
    checkTiming("clamp", 700);
    checkMemory("clamp_mem");

    for (int t = 0; t < 6; t++) begin
      s = int'($urandom_range(511, 0));
      d = int'($urandom_range(511, 0));
      l = int'($urandom_range(200, 1));
      modelCopy(s, d, l);
      applyStimulus(s, d, l, -1);
      checkTiming($sformatf("rand%0d", t), l);
      checkMemory($sformatf("rand%0d_mem", t));
    end

    for (int i = 0; i < 3; i++) exp_mem[350 + i] = exp_mem[300 + i];
    @(negedge clk);
    src   = 9'd300;
    dst   = 9'd350;
    len   = 10'd8;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    writes = 0;
    cyc    = 0;
    while (writes < 3 && cyc < 100) begin
      if (mem_load) writes++;
      cyc++;
      @(negedge clk);
    end
    checkOutput("midreset_writes_seen", writes, 3);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_load", mem_load, 0);
    checkOutput("midreset_done", done, 0);
    checkOutput("midreset_addr", mem_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkMemory("midreset_mem");

    modelCopy(300, 350, 8);
    applyStimulus(300, 350, 8, -1);
    checkTiming("after_reset", 8);
    checkMemory("after_reset_mem");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
